// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine: datapath command codes,
// sequencer states and error codes.
package conv_pkg;

    localparam logic [2:0] CMD_IDLE   = 3'd0;
    localparam logic [2:0] CMD_INPUT  = 3'd1;
    localparam logic [2:0] CMD_BIAS   = 3'd2;
    localparam logic [2:0] CMD_WEIGHT = 3'd3;
    localparam logic [2:0] CMD_CONV   = 3'd4;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CFG   = 2'd1;
    localparam logic [1:0] ERR_WDOG  = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IN,
        ST_BIAS,
        ST_WGT,
        ST_CONV,
        ST_GAP,
        ST_FIN
    } state_t;

    function automatic logic [2:0] state_cmd(input state_t s);
        case (s)
            ST_IN:   return CMD_INPUT;
            ST_BIAS: return CMD_BIAS;
            ST_WGT:  return CMD_WEIGHT;
            ST_CONV: return CMD_CONV;
            default: return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/conv_seq_watchdog.sv
// Phase watchdog: saturating counter, cleared by clr, advanced by en.
// expired flags the cycle whose increment brings the count to all-ones.
module conv_seq_watchdog #(
    parameter int WDOG_W = 24
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] CNT_MAX  = '1;
    localparam logic [WDOG_W-1:0] CNT_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
    localparam logic [WDOG_W-1:0] CNT_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer controller: latches config on start, walks input/bias load then a
// weight-load/compute pair per output-channel tile, one idle gap between commands.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int OC_TILE = 8,
    parameter int WDOG_W  = 24
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] cfg_flen,
    input  logic [8:0] cfg_in_ch,
    input  logic [8:0] cfg_out_ch,
    input  logic       input_done,
    input  logic       bias_done,
    input  logic       weight_done,
    input  logic       conv_done,
    output logic [2:0] command,
    output logic [5:0] flen,
    output logic [8:0] in_ch,
    output logic [8:0] oc_tile_len,
    output logic [8:0] tile_idx,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam logic [9:0] TILE10 = 10'(OC_TILE);
    localparam logic [8:0] TILE9  = 9'(OC_TILE);

    state_t     state_q, state_d;
    state_t     gap_next_q, gap_next_d;
    logic [2:0] cmd_q, cmd_d;
    logic [5:0] flen_q, flen_d;
    logic [8:0] in_ch_q, in_ch_d;
    logic [8:0] tile_len_q, tile_len_d;
    logic [8:0] tile_idx_q, tile_idx_d;
    logic [8:0] n_tiles_q, n_tiles_d;
    logic [8:0] last_len_q, last_len_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [1:0] err_code_q, err_code_d;

    logic [8:0] n_tiles_calc, last_len_calc;
    logic       cfg_zero, wdog_en, wdog_clr, wdog_expired;

    assign wdog_en  = (state_q == ST_IN) || (state_q == ST_BIAS) ||
                      (state_q == ST_WGT) || (state_q == ST_CONV);
    assign wdog_clr = (state_d != state_q);

    conv_seq_watchdog #(.WDOG_W(WDOG_W)) u_wdog (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_expired)
    );

    always_comb begin
        cfg_zero      = (cfg_flen == '0) || (cfg_in_ch == '0) || (cfg_out_ch == '0);
        n_tiles_calc  = 9'(({1'b0, cfg_out_ch} + TILE10 - 10'd1) / TILE10);
        last_len_calc = 9'({1'b0, cfg_out_ch} - ({1'b0, n_tiles_calc} - 10'd1) * TILE10);

        state_d    = state_q;
        gap_next_d = gap_next_q;
        cmd_d      = cmd_q;
        flen_d     = flen_q;
        in_ch_d    = in_ch_q;
        tile_len_d = tile_len_q;
        tile_idx_d = tile_idx_q;
        n_tiles_d  = n_tiles_q;
        last_len_d = last_len_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (cfg_zero) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_CFG;
                    end else begin
                        state_d    = ST_IN;
                        cmd_d      = CMD_INPUT;
                        busy_d     = 1'b1;
                        error_d    = 1'b0;
                        err_code_d = ERR_NONE;
                        flen_d     = cfg_flen;
                        in_ch_d    = cfg_in_ch;
                        tile_idx_d = '0;
                        n_tiles_d  = n_tiles_calc;
                        last_len_d = last_len_calc;
                        tile_len_d = (n_tiles_calc == 9'd1) ? last_len_calc : TILE9;
                    end
                end
            end
            ST_IN: begin
                if (input_done) begin
                    state_d    = ST_GAP;
                    gap_next_d = ST_BIAS;
                    cmd_d      = CMD_IDLE;
                end
            end
            ST_BIAS: begin
                if (bias_done) begin
                    state_d    = ST_GAP;
                    gap_next_d = ST_WGT;
                    cmd_d      = CMD_IDLE;
                end
            end
            ST_WGT: begin
                if (weight_done) begin
                    state_d    = ST_GAP;
                    gap_next_d = ST_CONV;
                    cmd_d      = CMD_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    cmd_d = CMD_IDLE;
                    if (tile_idx_q == n_tiles_q - 9'd1) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_GAP;
                        gap_next_d = ST_WGT;
                        tile_idx_d = tile_idx_q + 9'd1;
                        tile_len_d = (tile_idx_q + 9'd1 == n_tiles_q - 9'd1) ? last_len_q : TILE9;
                    end
                end
            end
            ST_GAP: begin
                state_d = gap_next_q;
                cmd_d   = state_cmd(gap_next_q);
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A phase that completes in its expiry cycle still counts as completed.
        if (wdog_expired && (state_d == state_q)) begin
            state_d    = ST_IDLE;
            cmd_d      = CMD_IDLE;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_WDOG;
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            cmd_d      = CMD_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            gap_next_q <= ST_IDLE;
            cmd_q      <= CMD_IDLE;
            flen_q     <= '0;
            in_ch_q    <= '0;
            tile_len_q <= '0;
            tile_idx_q <= '0;
            n_tiles_q  <= '0;
            last_len_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            gap_next_q <= gap_next_d;
            cmd_q      <= cmd_d;
            flen_q     <= flen_d;
            in_ch_q    <= in_ch_d;
            tile_len_q <= tile_len_d;
            tile_idx_q <= tile_idx_d;
            n_tiles_q  <= n_tiles_d;
            last_len_q <= last_len_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign command     = cmd_q;
    assign flen        = flen_q;
    assign in_ch       = in_ch_q;
    assign oc_tile_len = tile_len_q;
    assign tile_idx    = tile_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: table of layer configs plus
// hand sequences for abort, async reset and watchdog timeout.
module tb_conv_layer_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [5:0] cfg_flen = '0;
    logic [8:0] cfg_in_ch = '0, cfg_out_ch = '0;
    logic       input_done = 1'b0, bias_done = 1'b0, weight_done = 1'b0, conv_done = 1'b0;

    logic [2:0] command, command_w;
    logic [5:0] flen, flen_w;
    logic [8:0] in_ch, in_ch_w, oc_tile_len, oc_tile_len_w, tile_idx, tile_idx_w;
    logic       busy, busy_w, done, done_w, error, error_w;
    logic [1:0] err_code, err_code_w;

    always #5 clk = ~clk;

    conv_layer_sequencer #(.OC_TILE(8), .WDOG_W(24)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_flen(cfg_flen), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
        .input_done(input_done), .bias_done(bias_done),
        .weight_done(weight_done), .conv_done(conv_done),
        .command(command), .flen(flen), .in_ch(in_ch), .oc_tile_len(oc_tile_len),
        .tile_idx(tile_idx), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    conv_layer_sequencer #(.OC_TILE(8), .WDOG_W(4)) u_dut_w (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_flen(cfg_flen), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
        .input_done(input_done), .bias_done(bias_done),
        .weight_done(weight_done), .conv_done(conv_done),
        .command(command_w), .flen(flen_w), .in_ch(in_ch_w), .oc_tile_len(oc_tile_len_w),
        .tile_idx(tile_idx_w), .busy(busy_w), .done(done_w), .error(error_w), .err_code(err_code_w)
    );

    typedef struct {
        int flen;
        int in_ch;
        int out_ch;
        int exp_tiles;
        int exp_last;
        int exp_err;
    } vec_t;

    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_strobe(input int c, input logic v);
        case (c)
            1: input_done  = v;
            2: bias_done   = v;
            3: weight_done = v;
            4: conv_done   = v;
            default: ;
        endcase
    endtask

    task automatic set_cfg(input int f, input int ic, input int oc);
        cfg_flen   = 6'(f);
        cfg_in_ch  = 9'(ic);
        cfg_out_ch = 9'(oc);
    endtask

    // Holds each command for five cycles, strobes a foreign done on the way,
    // then checks the gap, the next command and the tile bookkeeping.
    task automatic run_vec(input vec_t v);
        int ncmd, c, stray, k;
        @(negedge clk);
        set_cfg(v.flen, v.in_ch, v.out_ch);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_cfg(0, 0, 0);
        if (v.exp_err != 0) begin
            chk("cfgerr_command", int'(command), 0);
            chk("cfgerr_busy", int'(busy), 0);
            chk("cfgerr_error", int'(error), 1);
            chk("cfgerr_code", int'(err_code), 1);
            @(negedge clk);
            chk("cfgerr_no_done", int'(done), 0);
            return;
        end
        chk("start_busy", int'(busy), 1);
        chk("start_error_clr", int'(error), 0);
        chk("start_code_clr", int'(err_code), 0);
        chk("latched_flen", int'(flen), v.flen);
        chk("latched_in_ch", int'(in_ch), v.in_ch);
        ncmd = 2 + 2 * v.exp_tiles;
        for (int p = 0; p < ncmd; p++) begin
            c = (p < 2) ? p + 1 : ((p % 2 == 0) ? 3 : 4);
            stray = (c % 4) + 1;
            chk("command", int'(command), c);
            if (c == 3) begin
                k = (p - 2) / 2;
                chk("tile_idx", int'(tile_idx), k);
                chk("oc_tile_len", int'(oc_tile_len), (k == v.exp_tiles - 1) ? v.exp_last : 8);
            end
            for (int w = 0; w < 4; w++) begin
                if (w == 1) set_strobe(stray, 1'b1);
                @(negedge clk);
                set_strobe(stray, 1'b0);
                chk("hold_command", int'(command), c);
            end
            set_strobe(c, 1'b1);
            @(negedge clk);
            set_strobe(c, 1'b0);
            chk("gap_command", int'(command), 0);
            if (p == ncmd - 1) begin
                chk("fin_done", int'(done), 1);
                chk("fin_busy", int'(busy), 1);
                @(negedge clk);
                chk("idle_done", int'(done), 0);
                chk("idle_busy", int'(busy), 0);
                chk("idle_command", int'(command), 0);
            end else begin
                chk("gap_done", int'(done), 0);
                @(negedge clk);
            end
        end
        chk("end_error", int'(error), 0);
        chk("end_flen", int'(flen), v.flen);
    endtask

    task automatic step_phase(input int c);
        chk("seq_command", int'(command), c);
        @(negedge clk);
        set_strobe(c, 1'b1);
        @(negedge clk);
        set_strobe(c, 1'b0);
        chk("seq_gap", int'(command), 0);
        @(negedge clk);
    endtask

    initial begin
        int cnt, guard;
        vecs[0] = '{32, 3, 20, 3, 4, 0};
        vecs[1] = '{5, 7, 16, 2, 8, 0};
        vecs[2] = '{1, 1, 1, 1, 1, 0};
        vecs[3] = '{10, 0, 8, 0, 0, 1};
        vecs[4] = '{8, 8, 9, 2, 1, 0};
        vecs[5] = '{0, 4, 4, 0, 0, 1};
        vecs[6] = '{63, 511, 511, 64, 7, 0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_command", int'(command), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_tile_len", int'(oc_tile_len), 0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort during CONV of tile 1, with a coincident conv_done.
        @(negedge clk);
        set_cfg(32, 3, 20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step_phase(1);
        step_phase(2);
        step_phase(3);
        step_phase(4);
        step_phase(3);
        chk("abort_pre_command", int'(command), 4);
        chk("abort_pre_tile", int'(tile_idx), 1);
        @(negedge clk);
        abort = 1'b1;
        conv_done = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        conv_done = 1'b0;
        chk("abort_command", int'(command), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_error", int'(error), 1);
        chk("abort_code", int'(err_code), 3);
        chk("abort_no_done", int'(done), 0);
        @(negedge clk);
        chk("abort_no_done_late", int'(done), 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", int'(busy), 0);
        chk("abort_start_code", int'(err_code), 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_command", int'(command), 1);
        chk("restart_error_clr", int'(error), 0);
        step_phase(1);
        chk("pre_reset_command", int'(command), 2);
        rstn = 1'b0;
        #1;
        chk("arst_command", int'(command), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_error", int'(error), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_flen", int'(flen), 0);
        chk("arst_in_ch", int'(in_ch), 0);
        chk("arst_tile_len", int'(oc_tile_len), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Watchdog on the narrow-counter instance; stray conv_done in WGT.
        @(negedge clk);
        set_cfg(4, 4, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wd_in", int'(command_w), 1);
        input_done = 1'b1;
        @(negedge clk);
        input_done = 1'b0;
        @(negedge clk);
        chk("wd_bias", int'(command_w), 2);
        bias_done = 1'b1;
        @(negedge clk);
        bias_done = 1'b0;
        @(negedge clk);
        chk("wd_wgt", int'(command_w), 3);
        cnt = 0;
        guard = 0;
        while (command_w == 3'd3 && guard < 100) begin
            cnt++;
            if (cnt == 3) conv_done = 1'b1;
            @(negedge clk);
            conv_done = 1'b0;
            guard++;
        end
        chk("wd_wgt_cycles", cnt, 15);
        chk("wd_command", int'(command_w), 0);
        chk("wd_busy", int'(busy_w), 0);
        chk("wd_error", int'(error_w), 1);
        chk("wd_code", int'(err_code_w), 2);
        chk("wd_wide_still_wgt", int'(command), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("wd_idle_abort_ignored", int'(err_code_w), 2);
        chk("wide_abort_code", int'(err_code), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
